// File: rtl/csr_pkg.sv
// Shared CSR definitions: address map, system-op encodings, trap causes and the
// access-controller state enum. The CSR register file uses the same address constants.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h000;
    localparam logic [11:0] CSR_MTVEC   = 12'h005;
    localparam logic [11:0] CSR_MEPC    = 12'h041;
    localparam logic [11:0] CSR_MCAUSE  = 12'h042;
    localparam logic [11:0] CSR_MIP     = 12'h044;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_CSRRW  = 3'd1;
    localparam logic [2:0] OP_CSRRWI = 3'd2;
    localparam logic [2:0] OP_ECALL  = 3'd3;
    localparam logic [2:0] OP_EBREAK = 3'd4;
    localparam logic [2:0] OP_MRET   = 3'd5;

    localparam int CAUSE_ECALL_DEF   = 11;
    localparam int CAUSE_EBREAK_DEF  = 3;
    localparam int CAUSE_ILLEGAL_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RW      = 3'd1,
        ST_T_EPC   = 3'd2,
        ST_T_CAUSE = 3'd3,
        ST_T_VEC   = 3'd4,
        ST_RET     = 3'd5
    } state_e;

    function automatic logic csr_known(input logic [11:0] addr);
        return (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) || (addr == CSR_MEPC) ||
               (addr == CSR_MCAUSE)  || (addr == CSR_MIP);
    endfunction

endpackage

// File: rtl/csr_access_ctrl.sv
// Initiator side of the CSR file port: sequences csrrw/csrrwi accesses, trap entry
// (mepc, mcause, vector fetch) and mret, returning rd writeback or a PC redirect.
module csr_access_ctrl
    import csr_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int CAUSE_ECALL   = CAUSE_ECALL_DEF,
    parameter int CAUSE_EBREAK  = CAUSE_EBREAK_DEF,
    parameter int CAUSE_ILLEGAL = CAUSE_ILLEGAL_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [11:0]     req_csr,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [4:0]      req_zimm,
    input  logic [4:0]      req_rd,
    input  logic [XLEN-1:0] req_pc,
    output logic            csr_w,
    output logic [11:0]     csr_addr,
    output logic [XLEN-1:0] csr_wdata,
    input  logic [XLEN-1:0] csr_rdata,
    output logic            rd_we,
    output logic [4:0]      rd_idx,
    output logic [XLEN-1:0] rd_data,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            busy
);

    state_e          state_q, state_d;
    logic [11:0]     csr_q, csr_d;
    logic [XLEN-1:0] operand_q, operand_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] cause_q, cause_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            csr_q     <= '0;
            operand_q <= '0;
            rd_q      <= '0;
            pc_q      <= '0;
            cause_q   <= '0;
        end else begin
            state_q   <= state_d;
            csr_q     <= csr_d;
            operand_q <= operand_d;
            rd_q      <= rd_d;
            pc_q      <= pc_d;
            cause_q   <= cause_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        csr_d       = csr_q;
        operand_d   = operand_q;
        rd_d        = rd_q;
        pc_d        = pc_q;
        cause_d     = cause_q;
        req_ready   = 1'b0;
        csr_w       = 1'b0;
        csr_addr    = '0;
        csr_wdata   = '0;
        rd_we       = 1'b0;
        rd_idx      = '0;
        rd_data     = '0;
        redirect    = 1'b0;
        redirect_pc = '0;

        unique case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    csr_d     = req_csr;
                    operand_d = (req_op == OP_CSRRWI) ? {{(XLEN-5){1'b0}}, req_zimm} : req_rs1;
                    rd_d      = req_rd;
                    pc_d      = req_pc;
                    case (req_op)
                        OP_NOP: ;
                        OP_CSRRW, OP_CSRRWI: begin
                            if (csr_known(req_csr)) begin
                                state_d = ST_RW;
                            end else begin
                                state_d = ST_T_EPC;
                                cause_d = XLEN'(CAUSE_ILLEGAL);
                            end
                        end
                        OP_ECALL: begin
                            state_d = ST_T_EPC;
                            cause_d = XLEN'(CAUSE_ECALL);
                        end
                        OP_EBREAK: begin
                            state_d = ST_T_EPC;
                            cause_d = XLEN'(CAUSE_EBREAK);
                        end
                        OP_MRET: state_d = ST_RET;
                        default: begin
                            state_d = ST_T_EPC;
                            cause_d = XLEN'(CAUSE_ILLEGAL);
                        end
                    endcase
                end
            end
            ST_RW: begin
                // Old value is read in the same cycle the new one is written
                csr_w     = 1'b1;
                csr_addr  = csr_q;
                csr_wdata = operand_q;
                rd_we     = (rd_q != 5'd0);
                rd_idx    = rd_q;
                rd_data   = csr_rdata;
                state_d   = ST_IDLE;
            end
            ST_T_EPC: begin
                csr_w     = 1'b1;
                csr_addr  = CSR_MEPC;
                csr_wdata = pc_q;
                state_d   = ST_T_CAUSE;
            end
            ST_T_CAUSE: begin
                csr_w     = 1'b1;
                csr_addr  = CSR_MCAUSE;
                csr_wdata = cause_q;
                state_d   = ST_T_VEC;
            end
            ST_T_VEC: begin
                csr_addr    = CSR_MTVEC;
                redirect    = 1'b1;
                redirect_pc = {csr_rdata[XLEN-1:2], 2'b00};
                state_d     = ST_IDLE;
            end
            ST_RET: begin
                csr_addr    = CSR_MEPC;
                redirect    = 1'b1;
                redirect_pc = csr_rdata;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = !req_ready;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Randomized bench for csr_access_ctrl: a behavioural CSR file plus a per-request
// reference model of expected writes, writeback, redirect and latency.
module tb_csr_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [11:0] req_csr;
    logic [31:0] req_rs1;
    logic [4:0]  req_zimm;
    logic [4:0]  req_rd;
    logic [31:0] req_pc;
    logic        csr_w;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        rd_we;
    logic [4:0]  rd_idx;
    logic [31:0] rd_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    csr_access_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_csr     (req_csr),
        .req_rs1     (req_rs1),
        .req_zimm    (req_zimm),
        .req_rd      (req_rd),
        .req_pc      (req_pc),
        .csr_w       (csr_w),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .rd_we       (rd_we),
        .rd_idx      (rd_idx),
        .rd_data     (rd_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .busy        (busy)
    );

    // Behavioural CSR file (environment), slots: mstatus, mtvec, mepc, mcause, mip
    function automatic int csr_slot(input logic [11:0] a);
        case (a)
            12'h000: return 0;
            12'h005: return 1;
            12'h041: return 2;
            12'h042: return 3;
            12'h044: return 4;
            default: return -1;
        endcase
    endfunction

    logic [31:0] env_mem [5];
    logic        bad_write = 1'b0;
    logic        preset_en = 1'b0;
    int          preset_slot = 0;
    logic [31:0] preset_val = '0;

    always_comb begin
        csr_rdata = '0;
        if (csr_slot(csr_addr) >= 0) csr_rdata = env_mem[csr_slot(csr_addr)];
    end

    always @(posedge clk) begin
        if (csr_w) begin
            if (csr_slot(csr_addr) >= 0) env_mem[csr_slot(csr_addr)] <= csr_wdata;
            else bad_write <= 1'b1;
        end else if (preset_en) begin
            env_mem[preset_slot] <= preset_val;
        end
    end

    logic [31:0] ref_mem [5];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preset(input int slot, input logic [31:0] v);
        preset_slot = slot;
        preset_val  = v;
        preset_en   = 1'b1;
        @(posedge clk);
        #1 preset_en = 1'b0;
        ref_mem[slot] = v;
        @(negedge clk);
    endtask

    task automatic check_file();
        for (int i = 0; i < 5; i++) check($sformatf("csr_slot%0d", i), env_mem[i], ref_mem[i]);
        check("no_unknown_write", 32'(bad_write), 32'd0);
    endtask

    // Spec latencies, counted with the accept cycle as cycle 1
    localparam int LAT_RW = 2, LAT_TRAP = 4, LAT_RET = 2;

    task automatic do_req(input int txn, input logic [2:0] op, input logic [11:0] csr,
                          input logic [31:0] rs1, input logic [4:0] zimm,
                          input logic [4:0] rd, input logic [31:0] pc);
        int          slot;
        logic [31:0] operand;
        int          exp_nw = 0;
        logic [11:0] exp_wa [2];
        logic [31:0] exp_wd [2];
        logic        exp_rdwe = 1'b0;
        logic [31:0] exp_rdval = '0;
        logic        exp_redir = 1'b0;
        logic [31:0] exp_rpc = '0;
        int          exp_lat = 1;
        int          exp_busy = 0;
        logic [31:0] cause = '0;
        logic        trap = 1'b0;
        logic [11:0] got_wa [$];
        logic [31:0] got_wd [$];
        int          n_rdwe = 0, rdwe_off = -1, n_redir = 0, redir_off = -1, busy_cnt = 0;
        logic [4:0]  got_idx = '0;
        logic [31:0] got_rdval = '0, got_rpc = '0;
        int          w = 0, off = 0;

        slot    = csr_slot(csr);
        operand = (op == 3'd2) ? {27'b0, zimm} : rs1;
        case (op)
            3'd1, 3'd2: begin
                if (slot >= 0) begin
                    exp_nw = 1; exp_wa[0] = csr; exp_wd[0] = operand;
                    exp_rdwe = (rd != 5'd0); exp_rdval = ref_mem[slot];
                    exp_lat = LAT_RW; exp_busy = 1;
                    ref_mem[slot] = operand;
                end else begin
                    trap = 1'b1; cause = 32'd2;
                end
            end
            3'd3: begin trap = 1'b1; cause = 32'd11; end
            3'd4: begin trap = 1'b1; cause = 32'd3; end
            3'd5: begin
                exp_redir = 1'b1; exp_rpc = ref_mem[2]; exp_lat = LAT_RET; exp_busy = 1;
            end
            3'd6, 3'd7: begin trap = 1'b1; cause = 32'd2; end
            default: ;
        endcase
        if (trap) begin
            exp_nw = 2;
            exp_wa[0] = 12'h041; exp_wd[0] = pc;
            exp_wa[1] = 12'h042; exp_wd[1] = cause;
            exp_redir = 1'b1; exp_rpc = ref_mem[1] & 32'hFFFF_FFFC;
            exp_lat = LAT_TRAP; exp_busy = 3;
            ref_mem[2] = pc; ref_mem[3] = cause;
        end

        while (!req_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        check("no_bubble", 32'(w), 32'd0);
        req_op = op; req_csr = csr; req_rs1 = rs1; req_zimm = zimm; req_rd = rd; req_pc = pc;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_op = 3'($urandom); req_csr = 12'($urandom); req_rs1 = $urandom;

        do begin
            @(negedge clk);
            off++;
            if (busy) busy_cnt++;
            if (csr_w) begin
                got_wa.push_back(csr_addr);
                got_wd.push_back(csr_wdata);
            end
            if (rd_we) begin
                n_rdwe++; rdwe_off = off; got_idx = rd_idx; got_rdval = rd_data;
            end
            if (redirect) begin
                n_redir++; redir_off = off; got_rpc = redirect_pc;
            end
        end while (!req_ready && off < 8);
        check("done_in_budget", 32'(req_ready), 32'd1);

        check("num_writes", 32'(got_wa.size()), 32'(exp_nw));
        for (int i = 0; i < exp_nw && i < got_wa.size(); i++) begin
            check($sformatf("waddr%0d", i), 32'(got_wa[i]), 32'(exp_wa[i]));
            check($sformatf("wdata%0d", i), got_wd[i], exp_wd[i]);
        end
        check("rd_we_count", 32'(n_rdwe), exp_rdwe ? 32'd1 : 32'd0);
        if (exp_rdwe) begin
            check("rd_we_latency", 32'(rdwe_off + 1), 32'(exp_lat));
            check("rd_idx", 32'(got_idx), 32'(rd));
            check("rd_data", got_rdval, exp_rdval);
        end
        check("redirect_count", 32'(n_redir), exp_redir ? 32'd1 : 32'd0);
        if (exp_redir) begin
            check("redirect_latency", 32'(redir_off + 1), 32'(exp_lat));
            check("redirect_pc", got_rpc, exp_rpc);
        end
        check("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
        check_file();
        $display("txn %0d op=%0d csr=%03h rd=%0d pc=%08h writes=%0d rd_we=%0d redirect=%0d pc_out=%08h",
                 txn, op, csr, rd, pc, got_wa.size(), n_rdwe, n_redir, got_rpc);
    endtask

    initial begin
        int          n_bad;
        logic [11:0] known [5];
        logic [11:0] c;
        logic [31:0] pcv;

        known[0] = 12'h000; known[1] = 12'h005; known[2] = 12'h041;
        known[3] = 12'h042; known[4] = 12'h044;
        rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_csr = '0; req_rs1 = '0;
        req_zimm = '0; req_rd = '0; req_pc = '0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_csr_w", 32'(csr_w), 32'd0);
        check("rst_csr_addr", 32'(csr_addr), 32'd0);
        check("rst_rd_we", 32'(rd_we), 32'd0);
        check("rst_redirect", 32'(redirect), 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) preset(i, 32'h0);

        // Directed scenarios
        do_req(1, 3'd1, 12'h005, 32'h0000_1000, 5'd0, 5'd5, 32'h10);
        check("mtvec_readback", env_mem[1], 32'h0000_1000);
        do_req(2, 3'd2, 12'h000, 32'hDEAD_BEEF, 5'h1F, 5'd0, 32'h14);
        preset(1, 32'h0000_0103);
        do_req(3, 3'd3, 12'h000, 32'h0, 5'd0, 5'd0, 32'h0000_0040);
        preset(2, 32'h0000_0044);
        do_req(4, 3'd5, 12'h000, 32'h0, 5'd0, 5'd0, 32'h0000_0048);
        do_req(5, 3'd1, 12'h300, 32'h1234_5678, 5'd0, 5'd7, 32'h0000_0080);

        // Reset during T_CAUSE of an EBREAK
        preset(3, 32'h0000_ABCD);
        req_op = 3'd4; req_csr = '0; req_rd = '0; req_pc = 32'h0000_0200; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_in_cause", 32'(csr_addr), 32'h042);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        check("rst_mid_csr_w", 32'(csr_w), 32'd0);
        ref_mem[2] = 32'h0000_0200;
        n_bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) rst_n = 1'b1;
            if (redirect || csr_w || !req_ready) n_bad++;
        end
        check("rst_mid_quiet", 32'(n_bad), 32'd0);
        check_file();
        $display("txn 6 ebreak aborted by reset, mcause=%08h", env_mem[3]);
        do_req(7, 3'd1, 12'h044, 32'hCAFE_0001, 5'd0, 5'd9, 32'h0000_0204);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 5) == 5) c = 12'($urandom);
            else c = known[$urandom_range(0, 4)];
            pcv = $urandom & 32'hFFFF_FFFC;
            do_req(100 + t, 3'($urandom_range(0, 7)), c, $urandom, 5'($urandom),
                   ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), pcv);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0x00000000 expected 0x00000001");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/csr_access_ctrl.md
Name: csr_access_ctrl

Overview:
- Initiator side of the CSR register-file port.
- Accepts one decoded system instruction at a time: csrrw, csrrwi, ecall, ebreak, mret, or an illegal op.
- Sequences the csr_w/csr_addr/data_in writes and data_out reads the CSR file needs.
- Returns the rd writeback value and the PC redirect (trap vector or mepc) to the core; stalls the core while busy.

Parameters:
- XLEN, 32, data/PC width.
- CAUSE_ECALL, 11, mcause value written on ecall.
- CAUSE_EBREAK, 3, mcause value written on ebreak.
- CAUSE_ILLEGAL, 2, mcause value written on illegal op or unknown CSR address.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  system instruction present
- req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready
- req_op  in  3  0 NOP, 1 CSRRW, 2 CSRRWI, 3 ECALL, 4 EBREAK, 5 MRET, 6-7 illegal
- req_csr  in  12  CSR address field inst[31:20]
- req_rs1  in  XLEN  rs1 register value (CSRRW source)
- req_zimm  in  5  inst[19:15], zero-extended for CSRRWI
- req_rd  in  5  destination register index
- req_pc  in  XLEN  PC of the instruction
- csr_w  out  1  CSR file write enable
- csr_addr  out  12  CSR file address
- csr_wdata  out  XLEN  CSR file data_in
- csr_rdata  in  XLEN  CSR file data_out (combinational read)
- rd_we  out  1  one-cycle register-file write strobe
- rd_idx  out  5  destination index
- rd_data  out  XLEN  old CSR value
- redirect  out  1  one-cycle PC redirect strobe
- redirect_pc  out  XLEN  redirect target
- busy  out  1  core stall, equals !req_ready

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0 except req_ready=1.
  - Captured request registers cleared.
  - Reset mid-sequence aborts it; no further CSR writes are issued.
- CSR map:
  - MSTATUS 0x000, MTVEC 0x005, MEPC 0x041, MCAUSE 0x042, MIP 0x044.
  - Any other address is unknown.
- On accept, latch op, csr, operand, rd and pc. The operand is rs1, or {27'b0, zimm} for CSRRWI.
- States: IDLE, RW, T_EPC, T_CAUSE, T_VEC, RET.
- IDLE accept transitions:
  - op 1 or 2 with a known address -> RW.
  - op 1 or 2 with an unknown address -> T_EPC, cause CAUSE_ILLEGAL.
  - op 3 -> T_EPC, cause CAUSE_ECALL.
  - op 4 -> T_EPC, cause CAUSE_EBREAK.
  - op 5 -> RET.
  - op 6-7 -> T_EPC, cause CAUSE_ILLEGAL.
  - op 0 is accepted and dropped, staying in IDLE with no outputs.
- RW (1 cycle):
  - csr_w=1, csr_addr=latched csr, csr_wdata=operand.
  - rd_data=csr_rdata, so rd gets the old value, sampled in the same cycle as the write edge.
  - rd_we=1 unless rd=0.
  - The CSR write always occurs, including when rd=0.
  - Next state IDLE.
  - Total latency: 2 cycles from accept to rd_we.
- T_EPC: csr_w=1, addr MEPC, wdata=latched pc. Next T_CAUSE.
- T_CAUSE: csr_w=1, addr MCAUSE, wdata=cause. Next T_VEC.
- T_VEC:
  - csr_w=0, addr MTVEC.
  - redirect=1, redirect_pc={csr_rdata[31:2],2'b00}.
  - Next IDLE.
  - Trap latency: 4 cycles accept-to-redirect; exactly 2 CSR writes.
- RET:
  - csr_w=0, addr MEPC.
  - redirect=1, redirect_pc=csr_rdata.
  - Next IDLE.
  - No CSR writes; mstatus is not modified.
- Only one of rd_we/redirect is ever asserted per request. Neither is asserted for NOP.
- csr_w is never high in IDLE, T_VEC or RET.
- req_valid while busy: ignored; the request is held by the core.
- Back-to-back requests: the next request is accepted in the first IDLE cycle after completion. There is no bubble beyond that.
- No CSR write sequence is interrupted except by reset.

Decomposition:
- Shared package csr_pkg:
  - CSR address constants.
  - op encodings.
  - cause constants.
  - FSM state enum.
- The CSR register file reuses the same address constants from this package.
- No sub-module; a single FSM plus request-latch registers.

Test Plan:
1. CSRRW, csr=0x005, rs1=0x0000_1000, rd=5, mtvec preset 0x0 -> one-cycle csr_w, addr 0x005, wdata 0x1000; rd_we=1, rd_idx=5, rd_data=0; mtvec reads back 0x1000.
2. CSRRWI, csr=0x000, zimm=0x1F, rd=0 -> csr_w with wdata 0x0000_001F; rd_we stays 0.
3. With mtvec=0x0000_0103, ECALL at pc 0x0000_0040 -> writes mepc=0x40 then mcause=11 on consecutive cycles; redirect=1 with redirect_pc=0x0000_0100 exactly 4 cycles after accept; busy high for 3 cycles.
4. MRET with mepc=0x0000_0044 -> redirect_pc=0x44, 2 cycles after accept; csr_w never asserted.
5. CSRRW to csr=0x300 (unknown) at pc 0x80 -> no write to 0x300; mepc=0x80, mcause=2, redirect to mtvec.
6. rst_n pulsed low during T_CAUSE of an EBREAK -> mcause is not written, redirect never asserted, req_ready=1 immediately; a following CSRRW completes normally.
